// File: rtl/dly_memory_pkg.sv
// Shared types for the delayed main-memory model.
// Default geometry matches the PDP-6 core address space.
package dly_memory_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 36;

  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/dly_memory.sv
// Word-addressed memory with fixed access delay behind
// a waitrequest-style slave port.
module dly_memory
  import dly_memory_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DELAY  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_write,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_writedata,
  output logic [DATA_W-1:0] o_readdata,
  output logic              o_waitrequest
);

  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DELAY - 1);

  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_wr;

  logic w_req;
  logic w_done;

  assign w_req  = i_read | i_write;
  assign w_done = (r_state == BUSY) && w_req && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_is_wr       <= 1'b0;
      o_waitrequest <= 1'b1;
      o_readdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          o_waitrequest <= 1'b1;
          if (w_req) begin
            r_state <= BUSY;
            r_cnt   <= CNT_LOAD;
            r_addr  <= i_address;
            r_wdata <= i_writedata;
            r_is_wr <= i_write;
          end
        end
        BUSY: begin
          // Master withdrew the request: drop it silently.
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state       <= ACK;
            o_waitrequest <= 1'b0;
            if (!r_is_wr) o_readdata <= mem[r_addr];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK: begin
          r_state       <= IDLE;
          o_waitrequest <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          o_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset so preloaded contents survive it.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_done && r_is_wr) mem[r_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_dly_memory.sv
// Directed bench for dly_memory: default, DELAY=1 and
// DELAY=20 instances driven by one linear sequence.
module tb_dly_memory;

  logic        clk;
  logic        rst;
  logic [17:0] addr [3];
  logic        wr   [3];
  logic        rd   [3];
  logic [35:0] wd   [3];
  logic [35:0] rdq  [3];
  logic        wq   [3];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dly_memory u8 (
    .i_clk(clk), .i_reset(rst), .i_address(addr[0]),
    .i_write(wr[0]), .i_read(rd[0]), .i_writedata(wd[0]),
    .o_readdata(rdq[0]), .o_waitrequest(wq[0])
  );

  dly_memory #(.DELAY(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_address(addr[1]),
    .i_write(wr[1]), .i_read(rd[1]), .i_writedata(wd[1]),
    .o_readdata(rdq[1]), .o_waitrequest(wq[1])
  );

  dly_memory #(.DELAY(20)) u20 (
    .i_clk(clk), .i_reset(rst), .i_address(addr[2]),
    .i_write(wr[2]), .i_read(rd[2]), .i_writedata(wd[2]),
    .o_readdata(rdq[2]), .o_waitrequest(wq[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; lat is edges from E0 to ACK entry, -1 on timeout.
  task automatic xfer(input int k, input logic r, input logic w,
                      input logic [17:0] a, input logic [35:0] d,
                      output int lat, output logic [35:0] q);
    int n;
    n = 0;
    lat = -1;
    rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
    do begin
      @(negedge clk);
      n++;
    end while (wq[k] !== 1'b0 && n < 300);
    if (wq[k] === 1'b0) lat = n - 1;
    q = rdq[k];
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 64'(wq[k]), 64'd1);
  endtask

  // Holds a read high across two transfers and measures ACK spacing.
  task automatic b2b(input int k, input int dly);
    int n;
    int g;
    logic after;
    n = 0;
    g = 0;
    rd[k] = 1'b1; wr[k] = 1'b0; addr[k] = 18'd3;
    do begin
      @(negedge clk);
      n++;
    end while (wq[k] !== 1'b0 && n < 300);
    @(negedge clk);
    g = 1;
    after = wq[k];
    while (wq[k] !== 1'b0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    rd[k] = 1'b0;
    chk("b2b_idle_gap", 64'(after), 64'd1);
    chk("b2b_spacing", 64'(g), 64'(dly + 2));
    @(negedge clk);
  endtask

  int          lat;
  logic [35:0] q;
  int          seen_ack;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wr[i] = 1'b0; rd[i] = 1'b0; wd[i] = '0;
    end
    u8.mem[4] = 36'd123;
    u8.mem[5] = 36'd321;
    u8.mem[9] = 36'd99;
    repeat (3) @(negedge clk);
    chk("rst_waitreq", 64'(wq[0]), 64'd1);
    chk("rst_readdata", 64'(rdq[0]), 64'd0);
    chk("rst_mem4", 64'(u8.mem[4]), 64'd123);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_waitreq", 64'(wq[0]), 64'd1);

    xfer(0, 1'b0, 1'b1, 18'd4, 36'o44556677, lat, q);
    chk("wr_latency", 64'(lat), 64'd8);
    chk("wr_mem4", 64'(u8.mem[4]), 64'(36'o44556677));
    chk("wr_mem5", 64'(u8.mem[5]), 64'd321);
    chk("wr_rdata_held", 64'(rdq[0]), 64'd0);

    xfer(0, 1'b1, 1'b0, 18'd5, '0, lat, q);
    chk("rd5_latency", 64'(lat), 64'd8);
    chk("rd5_data", 64'(q), 64'd321);
    xfer(0, 1'b1, 1'b0, 18'd4, '0, lat, q);
    chk("rd4_data", 64'(q), 64'(36'o44556677));
    chk("rd4_data_hold", 64'(rdq[0]), 64'(36'o44556677));

    xfer(0, 1'b1, 1'b1, 18'd7, 36'o777, lat, q);
    chk("rw_latency", 64'(lat), 64'd8);
    chk("rw_mem7", 64'(u8.mem[7]), 64'o777);
    chk("rw_rdata", 64'(rdq[0]), 64'(36'o44556677));

    // Abort by dropping the request mid-BUSY.
    seen_ack = 0;
    wr[0] = 1'b1; addr[0] = 18'd9; wd[0] = 36'd55;
    repeat (3) @(negedge clk);
    wr[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wq[0] === 1'b0) seen_ack++;
    end
    chk("abort_drop_ack", 64'(seen_ack), 64'd0);
    chk("abort_drop_mem9", 64'(u8.mem[9]), 64'd99);

    // Abort by reset with the write still held.
    seen_ack = 0;
    wr[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wq[0] === 1'b0) seen_ack++;
    end
    chk("abort_rst_ack", 64'(seen_ack), 64'd0);
    chk("abort_rst_mem9", 64'(u8.mem[9]), 64'd99);
    chk("abort_rst_waitreq", 64'(wq[0]), 64'd1);
    chk("abort_rst_rdata", 64'(rdq[0]), 64'd0);

    xfer(1, 1'b0, 1'b1, 18'd3, 36'o123456701234, lat, q);
    chk("d1_wr_latency", 64'(lat), 64'd1);
    xfer(1, 1'b1, 1'b0, 18'd3, '0, lat, q);
    chk("d1_rd_latency", 64'(lat), 64'd1);
    chk("d1_rd_data", 64'(q), 64'(36'o123456701234));
    b2b(1, 1);

    xfer(2, 1'b0, 1'b1, 18'd3, 36'o765432107654, lat, q);
    chk("d20_wr_latency", 64'(lat), 64'd20);
    xfer(2, 1'b1, 1'b0, 18'd3, '0, lat, q);
    chk("d20_rd_latency", 64'(lat), 64'd20);
    chk("d20_rd_data", 64'(q), 64'(36'o765432107654));
    b2b(2, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
